sumador_serial: RTL and testbench

SUMADOR_SERIAL -- requirements
Module: sumador_serial

---
 rtl/sumador_serial.sv | 71 +++++++
 tb/tb_sumador_serial.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sumador_serial.sv
// sumador_serial: bit-serial adder/subtractor, one full-adder bit per clock, LSB first
module sumador_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             Sub,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             Ov,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-2:0] sh;
    logic [WIDTH-1:0] sh_cat;
    logic [CW-1:0]    cnt;
    logic             c, sum_bit, c_next, last, accept;
    // Full-adder slice, end-of-operand detect and next-state decode
    always_comb begin
        accept     = start && (state != RUN);
        sum_bit    = a_reg[0] ^ b_reg[0] ^ c;
        c_next     = (a_reg[0] & b_reg[0]) | (a_reg[0] & c) | (b_reg[0] & c);
        last       = (state == RUN) && (cnt == CW'(WIDTH - 1));
        sh_cat     = {sum_bit, sh};
        state_next = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
        busy       = (state == RUN);
        done       = (state == DONE);
    end
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end
    // Operand shifters, carry, partial-sum shifter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sh    <= '0;
            S     <= '0;
            Co    <= 1'b0;
            Ov    <= 1'b0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= Sub ? ~B : B;
            c     <= Ci ^ Sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            c     <= c_next;
            sh    <= sh_cat[WIDTH-1:1];
            cnt   <= cnt + CW'(1);
            if (last) begin
                S  <= sh_cat;
                Co <= c_next;
                Ov <= c ^ c_next;
            end
        end
    end
endmodule

// File: tb/tb_sumador_serial.sv
// tb_sumador_serial: vector table, back-to-back, reset-abort and random checks against a reference model
module tb_sumador_serial;
    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ov;
    } exp_t;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sub;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, start, Ci, Sub;
    logic [7:0] A, B, S;
    logic       Co, Ov, busy, done;
    int         checks = 0;
    int         errors = 0;
    exp_t       q[$];

    sumador_serial #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Ci(Ci), .Sub(Sub),
        .S(S), .Co(Co), .Ov(Ov), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
        exp_t       e;
        logic [8:0] f;
        int         r;
        f    = sub ? ({1'b0, a} - {1'b0, b} - 9'(ci)) : ({1'b0, a} + {1'b0, b} + 9'(ci));
        r    = sub ? (int'($signed(a)) - int'($signed(b)) - int'(ci))
                   : (int'($signed(a)) + int'($signed(b)) + int'(ci));
        e.s  = f[7:0];
        e.co = sub ? ~f[8] : f[8];
        e.ov = (r > 127) || (r < -128);
        return e;
    endfunction

    // Scoreboard: every done pulse pops and compares one expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected no result pending");
            end else begin
                exp_t e;
                e = q.pop_front();
                check("S", 32'(S), 32'(e.s));
                check("Co", 32'(Co), 32'(e.co));
                check("Ov", 32'(Ov), 32'(e.ov));
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub, input exp_t e);
        int         n, nb;
        logic [7:0] s0;
        logic       hold_bad;
        n = 0;
        nb = 0;
        hold_bad = 1'b0;
        s0 = S;
        q.push_back(e);
        A = a; B = b; Ci = ci; Sub = sub; start = 1'b1;
        do begin
            @(negedge clk);
            start = 1'b0;
            A = 8'($urandom); B = 8'($urandom); Ci = 1'($urandom); Sub = 1'($urandom);
            n++;
            if (busy) begin
                nb++;
                if (S !== s0) hold_bad = 1'b1;
            end
        end while (!done && n < 40);
        check("latency", 32'(n), 32'd9);
        check("busy_cycles", 32'(nb), 32'd8);
        check("S_hold_during_run", 32'(hold_bad), 32'd0);
    endtask

    initial begin
        vec_t vt[7];
        int   n;
        vt[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, '{8'h10, 1'b0, 1'b0}};
        vt[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b1}};
        vt[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, '{8'h01, 1'b1, 1'b0}};
        vt[3] = '{8'h05, 8'h07, 1'b0, 1'b1, '{8'hFE, 1'b0, 1'b0}};
        vt[4] = '{8'h80, 8'h01, 1'b0, 1'b1, '{8'h7F, 1'b1, 1'b1}};
        vt[5] = '{8'hFF, 8'hFF, 1'b1, 1'b1, '{8'hFF, 1'b0, 1'b0}};
        vt[6] = '{8'h00, 8'h00, 1'b0, 1'b0, '{8'h00, 1'b0, 1'b0}};

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Ci = 1'b0; Sub = 1'b0;
        #1;
        check("reset_S", 32'(S), 32'd0);
        check("reset_Co", 32'(Co), 32'd0);
        check("reset_Ov", 32'(Ov), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_op(vt[i].a, vt[i].b, vt[i].ci, vt[i].sub, vt[i].e);

        // start held high with changing operands during RUN, then back-to-back accept in DONE
        q.push_back('{8'h10, 1'b0, 1'b0});
        A = 8'h0F; B = 8'h01; Ci = 1'b0; Sub = 1'b0; start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!done) begin
                A = 8'($urandom); B = 8'($urandom); Ci = 1'($urandom); Sub = 1'($urandom); start = 1'b1;
            end
        end while (!done && n < 40);
        check("b2b_first_latency", 32'(n), 32'd9);
        q.push_back('{8'h7F, 1'b1, 1'b1});
        A = 8'h80; B = 8'h01; Ci = 1'b0; Sub = 1'b1; start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!done && n < 40);
        check("b2b_second_latency", 32'(n), 32'd9);
        @(negedge clk);

        // Reset asserted at RUN bit 4 clears outputs immediately and aborts the operation
        A = 8'h33; B = 8'h44; Ci = 1'b0; Sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_S", 32'(S), 32'd0);
        check("abort_Co", 32'(Co), 32'd0);
        check("abort_Ov", 32'(Ov), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n++;
        end
        check("no_done_after_abort", 32'(n), 32'd0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, '{8'h02, 1'b0, 1'b0});

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            logic       ci, sub;
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); sub = 1'($urandom);
            run_op(a, b, ci, sub, model(a, b, ci, sub));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
